rule90_seed_loader: RTL



---
 rtl/rule90_seed_loader.sv | 55 +++++
 1 files changed

// File: rtl/rule90_seed_loader.sv
// rule90_seed_loader: assembles a seed from a word stream, loads it into the automaton, then counts generations.
module rule90_seed_loader #(
  parameter int WORD_W = 32,
  parameter int CELLS = 512,
  parameter int GEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic [GEN_W-1:0]  cfg_gens,
  output logic              load,
  output logic [CELLS-1:0]  data,
  output logic [GEN_W-1:0]  gen_count,
  output logic              gen_done,
  output logic              busy
);
  localparam int NWORDS = CELLS / WORD_W;
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  typedef enum logic [1:0] {FILL, LOAD, RUN} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [GEN_W-1:0] n;
  logic acc, last, hit;
  always_comb begin
    s_ready = state == FILL;
    load = state == LOAD;
    busy = state != FILL;
    acc = s_valid && s_ready;
    last = idx == IW'(NWORDS - 1);
    hit = gen_count == n;
    // a reset in the final RUN cycle suppresses the pulse
    gen_done = state == RUN && hit && !reset;
    state_n = state == FILL ? (acc && last ? LOAD : FILL) :
              state == LOAD ? RUN : (hit ? FILL : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      idx <= '0;
      data <= '0;
      gen_count <= '0;
      n <= '0;
    end else begin
      state <= state_n;
      for (int i = 0; i < NWORDS; i++)
        if (acc && idx == IW'(i)) data[i*WORD_W +: WORD_W] <= s_data;
      if (acc) idx <= last ? '0 : idx + 1'b1;
      if (acc && last) n <= cfg_gens;
      if (state == LOAD) gen_count <= '0;
      else if (state == RUN && !hit) gen_count <= gen_count + 1'b1;
    end
  end
endmodule
